udp_packet_rx: RTL and testbench
================================

UDP_PACKET_RX -- requirements
Module: udp_packet_rx

Interface
REQ-001 SHALL have parameter LOCAL_MAC, 48'h00_0A_35_01_02_03, accepted destination MAC (broadcast FF_FF_FF_FF_FF_FF is also accepted).
REQ-002 SHALL have parameter LOCAL_IP, 32'hC0_A8_00_62, accepted destination IP.
REQ-003 SHALL have parameter LOCAL_PORT, 16'd54321, accepted destination UDP port.
REQ-004 SHALL have parameter MAX_PAYLOAD, 16'd1472, largest accepted payload byte count.
REQ-005 SHALL have parameter GAP_TIMEOUT, 16'd1000, max idle cycles (rx_valid low) tolerated mid-frame.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port rx_data, input, 8: received byte.
REQ-009 SHALL have port rx_valid, input, 1: rx_data is valid this cycle; the byte is consumed unconditionally.
REQ-010 SHALL have port pl_data, output, 8: payload byte.
REQ-011 SHALL have port pl_valid, output, 1: pl_data is valid (one-cycle pulse per byte).
REQ-012 SHALL have port pl_first, output, 1: first payload byte of the packet.
REQ-013 SHALL have port pl_last, output, 1: last payload byte of the packet.
REQ-014 SHALL have port pkt_ok, output, 1: one-cycle pulse when a packet is fully accepted.
REQ-015 SHALL have port pkt_err, output, 1: one-cycle pulse when a frame is rejected.
REQ-016 SHALL have port err_code, output, 4: reason for the last rejection; held until the next pkt_err.
REQ-017 SHALL have port src_ip, output, 32: source IP of the current/last packet.
REQ-018 SHALL have port src_port, output, 16: source port of the current/last packet.
REQ-019 SHALL have port pl_len, output, 16: UDP length minus 8 of the current/last packet.

Function
REQ-020 SHALL implement the states HUNT, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD; the state and byte counter advance only on rx_valid.
REQ-021 Preamble handling:
- HUNT: byte 0x55 -> PREAMBLE (count=1).
- PREAMBLE: 0x55 increments the count, saturating at 7.
- PREAMBLE: 0xD5 with count>=5 -> ETH_HDR; any other byte -> HUNT with pkt_err and code 9 (bad SFD).
REQ-022 ETH_HDR SHALL take 14 bytes (dst MAC, src MAC, EtherType), MSB first. Checks:
- dst MAC not LOCAL_MAC and not broadcast -> code 1.
- EtherType not 0x0800 -> code 2.
REQ-023 IP_HDR SHALL take 20 bytes. Checks:
- byte0 not 0x45, or byte9 not 0x11 -> code 3.
- dst IP (bytes16-19) not LOCAL_IP -> code 4.
- Latch src_ip from bytes12-15.
- The total-length field is not checked.
REQ-024 UDP_HDR SHALL take 8 bytes. Checks:
- dst port not LOCAL_PORT -> code 6.
- length<8 or length>8+MAX_PAYLOAD -> code 7.
- Latch src_port and pl_len.
- The UDP checksum is ignored.
REQ-025 Each field SHALL be checked at its final byte; on mismatch the FSM goes to HUNT on the next edge, and pkt_err plus err_code are registered one cycle after that byte.
REQ-026 PAYLOAD SHALL forward exactly pl_len bytes:
- pl_data/pl_valid appear one cycle after the input byte (latency 1).
- pl_first is asserted with byte 0, and pl_last plus pkt_ok with byte pl_len-1.
- After the last byte the FSM returns to HUNT.
REQ-027 A one-byte payload SHALL assert pl_first, pl_last and pkt_ok in the same cycle.
REQ-028 When pl_len=0, pkt_ok SHALL pulse one cycle after the final UDP header byte, with no pl_valid.
REQ-029 In any state other than HUNT, GAP_TIMEOUT consecutive cycles with rx_valid low SHALL cause HUNT plus pkt_err with code 8; the gap counter clears on every rx_valid.
REQ-030 Bytes following a completed or rejected frame SHALL be parsed from HUNT; no end-of-frame input exists.
REQ-031 err_code values: 0 none, 1 MAC, 2 EtherType, 3 version/protocol, 4 dst IP, 5 IP checksum, 6 port, 7 length, 8 timeout, 9 SFD.

Reset
REQ-032 While reset_n=0:
- State SHALL be HUNT and all counters zero.
- pl_valid, pl_first, pl_last, pkt_ok and pkt_err SHALL be 0.
- pl_data, err_code, src_ip, src_port and pl_len SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame silently (no pkt_err); parsing resumes in HUNT after release.

Configuration
REQ-034 With UDP_RX_IP_CSUM_EN defined, the block SHALL verify the IP header checksum:
- Form the 16-bit ones'-complement sum (end-around carry) of the ten IP header words.
- A sum other than 0xFFFF after byte 19 SHALL reject the frame with code 5.
- The dst-IP check (code 4) takes priority over the checksum check.
REQ-035 Without UDP_RX_IP_CSUM_EN, the checksum field SHALL be ignored and no summing logic instantiated.

Verification
REQ-036 Broadcast frame: 7x0x55, 0xD5, dst IP C0A80062, port 54321, length 20, payload "Hello World!" -> 12 pl_valid pulses 0x48..0x21; pl_first on 0x48; pl_last plus pkt_ok on 0x21; src_port=12345, pl_len=12.
REQ-037 Same frame with dst port 1234 -> pkt_err with code 6, no pl_valid; an immediately following good frame -> pkt_ok.
REQ-038 Preamble 0x55,0x55,0xD5 -> pkt_err with code 9; UDP length 7 -> code 7; UDP length 8 -> pkt_ok with no pl_valid.
REQ-039 rx_valid low for 1000 cycles after IP byte 5 -> pkt_err with code 8; a gap of 999 cycles -> frame still accepted.
REQ-040 With UDP_RX_IP_CSUM_EN, checksum 0x0000 on a header whose correct checksum is non-zero -> code 5; correct checksum -> pkt_ok; without the macro, both -> pkt_ok.
REQ-041 Assert reset_n low during payload byte 6 -> outputs zero, no pkt_err; a full frame after release -> pkt_ok.

Source files
------------

// File: rtl/udp_packet_rx.sv
// rtl/udp_packet_rx.sv - UDP/IPv4/Ethernet frame receiver with payload extraction (optional UDP_RX_IP_CSUM_EN)
module udp_packet_rx #(
    parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_01_02_03,
    parameter logic [31:0] LOCAL_IP    = 32'hC0_A8_00_62,
    parameter logic [15:0] LOCAL_PORT  = 16'd54321,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472,
    parameter logic [15:0] GAP_TIMEOUT = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pl_first,
    output logic        pl_last,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [3:0]  err_code,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [15:0] pl_len
);

    typedef enum logic [2:0] {HUNT, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] gap_cnt, gap_nxt;
    logic [39:0] sr;
    logic        err_now, ok_now, pl_now, first_now, last_now;
    logic [3:0]  err_val;
    logic        ld_src_ip, ld_src_port, ld_len;
    logic        csum_bad;
    logic        len_bad;

    // Multi-byte fields are compared at their last byte: history bytes plus the current one.
    logic [47:0] field48;
    logic [31:0] field32;
    logic [15:0] field16;
    assign field48 = {sr, rx_data};
    assign field32 = {sr[23:0], rx_data};
    assign field16 = {sr[7:0], rx_data};
    assign len_bad = (field16 < 16'd8) || ({1'b0, field16} > (17'd8 + {1'b0, MAX_PAYLOAD}));

`ifdef UDP_RX_IP_CSUM_EN
    logic [15:0] csum, csum_nxt;
    logic [16:0] csum_add;
    assign csum_add = {1'b0, csum} + {1'b0, field16};
    assign csum_nxt = csum_add[15:0] + {15'd0, csum_add[16]};
    assign csum_bad = (csum_nxt != 16'hFFFF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum <= 16'd0;
        end else if (rx_valid) begin
            if (state != IP_HDR)
                csum <= 16'd0;
            else if (cnt[0])
                csum <= csum_nxt;
        end
    end
`else
    assign csum_bad = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gap_nxt     = gap_cnt;
        err_now     = 1'b0;
        err_val     = 4'd0;
        ok_now      = 1'b0;
        pl_now      = 1'b0;
        first_now   = 1'b0;
        last_now    = 1'b0;
        ld_src_ip   = 1'b0;
        ld_src_port = 1'b0;
        ld_len      = 1'b0;
        if (rx_valid) begin
            gap_nxt = 16'd0;
            cnt_nxt = cnt + 16'd1;
            case (state)
                HUNT: begin
                    cnt_nxt = 16'd0;
                    if (rx_data == 8'h55) begin
                        state_nxt = PREAMBLE;
                        cnt_nxt   = 16'd1;
                    end
                end
                PREAMBLE: begin
                    if (rx_data == 8'h55) begin
                        cnt_nxt = (cnt == 16'd7) ? 16'd7 : cnt + 16'd1;
                    end else if (rx_data == 8'hD5 && cnt >= 16'd5) begin
                        state_nxt = ETH_HDR;
                        cnt_nxt   = 16'd0;
                    end else begin
                        err_now = 1'b1;
                        err_val = 4'd9;
                    end
                end
                ETH_HDR: begin
                    if (cnt == 16'd5 && field48 != LOCAL_MAC && field48 != '1) begin
                        err_now = 1'b1;
                        err_val = 4'd1;
                    end else if (cnt == 16'd13) begin
                        if (field16 != 16'h0800) begin
                            err_now = 1'b1;
                            err_val = 4'd2;
                        end else begin
                            state_nxt = IP_HDR;
                            cnt_nxt   = 16'd0;
                        end
                    end
                end
                IP_HDR: begin
                    if ((cnt == 16'd0 && rx_data != 8'h45) || (cnt == 16'd9 && rx_data != 8'h11)) begin
                        err_now = 1'b1;
                        err_val = 4'd3;
                    end else if (cnt == 16'd15) begin
                        ld_src_ip = 1'b1;
                    end else if (cnt == 16'd19) begin
                        if (field32 != LOCAL_IP) begin
                            err_now = 1'b1;
                            err_val = 4'd4;
                        end else if (csum_bad) begin
                            err_now = 1'b1;
                            err_val = 4'd5;
                        end else begin
                            state_nxt = UDP_HDR;
                            cnt_nxt   = 16'd0;
                        end
                    end
                end
                UDP_HDR: begin
                    if (cnt == 16'd1) begin
                        ld_src_port = 1'b1;
                    end else if (cnt == 16'd3 && field16 != LOCAL_PORT) begin
                        err_now = 1'b1;
                        err_val = 4'd6;
                    end else if (cnt == 16'd5) begin
                        ld_len = 1'b1;
                        if (len_bad) begin
                            err_now = 1'b1;
                            err_val = 4'd7;
                        end
                    end else if (cnt == 16'd7) begin
                        cnt_nxt = 16'd0;
                        if (pl_len == 16'd0) begin
                            ok_now    = 1'b1;
                            state_nxt = HUNT;
                        end else begin
                            state_nxt = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    pl_now    = 1'b1;
                    first_now = (cnt == 16'd0);
                    if (cnt == pl_len - 16'd1) begin
                        last_now  = 1'b1;
                        ok_now    = 1'b1;
                        state_nxt = HUNT;
                        cnt_nxt   = 16'd0;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    cnt_nxt   = 16'd0;
                end
            endcase
        end else if (state != HUNT) begin
            if (gap_cnt == GAP_TIMEOUT - 16'd1) begin
                err_now = 1'b1;
                err_val = 4'd8;
            end else begin
                gap_nxt = gap_cnt + 16'd1;
            end
        end
        if (err_now) begin
            state_nxt = HUNT;
            cnt_nxt   = 16'd0;
            gap_nxt   = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= HUNT;
            cnt      <= 16'd0;
            gap_cnt  <= 16'd0;
            sr       <= 40'd0;
            pl_data  <= 8'd0;
            pl_valid <= 1'b0;
            pl_first <= 1'b0;
            pl_last  <= 1'b0;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            err_code <= 4'd0;
            src_ip   <= 32'd0;
            src_port <= 16'd0;
            pl_len   <= 16'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            gap_cnt  <= gap_nxt;
            pl_valid <= pl_now;
            pl_first <= first_now;
            pl_last  <= last_now;
            pkt_ok   <= ok_now;
            pkt_err  <= err_now;
            if (rx_valid)
                sr <= {sr[31:0], rx_data};
            if (pl_now)
                pl_data <= rx_data;
            if (err_now)
                err_code <= err_val;
            if (ld_src_ip)
                src_ip <= field32;
            if (ld_src_port)
                src_port <= field16;
            if (ld_len)
                pl_len <= field16 - 16'd8;
        end
    end

endmodule

// File: tb/tb_udp_packet_rx.sv
// tb/tb_udp_packet_rx.sv - directed self-checking bench for udp_packet_rx
module tb_udp_packet_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  pl_data;
    logic        pl_valid, pl_first, pl_last, pkt_ok, pkt_err;
    logic [3:0]  err_code;
    logic [31:0] src_ip;
    logic [15:0] src_port, pl_len;

    udp_packet_rx dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_first(pl_first), .pl_last(pl_last),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code),
        .src_ip(src_ip), .src_port(src_port), .pl_len(pl_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_pl = 0, n_first = 0, n_last = 0, n_ok = 0, n_err = 0, n_ok_last = 0, n_fl_ok = 0;
    int ok_cyc = -1, err_cyc = -1, mark_cyc = -2;
    logic [7:0] first_byte = 8'd0, last_byte = 8'd0;
    logic [7:0] pl_log[$];
    logic [7:0] fq[$];
    logic [7:0] hello [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                               8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    int b_pl, b_first, b_last, b_ok, b_err, b_ok_last, b_fl_ok, b_plq;

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MAC   = 48'h000A_3501_0203;
    localparam logic [31:0] IP_OK = 32'hC0A8_0062;
    localparam logic [15:0] CS_OK = 16'hB911;
    localparam logic [15:0] PORT  = 16'd54321;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pl_valid) begin
            pl_log.push_back(pl_data);
            n_pl <= n_pl + 1;
            if (pl_first) begin
                n_first <= n_first + 1;
                first_byte <= pl_data;
            end
            if (pl_last) begin
                n_last <= n_last + 1;
                last_byte <= pl_data;
            end
            if (pkt_ok && pl_last) n_ok_last <= n_ok_last + 1;
            if (pkt_ok && pl_first && pl_last) n_fl_ok <= n_fl_ok + 1;
        end
        if (pkt_ok) begin
            n_ok <= n_ok + 1;
            ok_cyc <= cyc;
        end
        if (pkt_err) begin
            n_err <= n_err + 1;
            err_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_pl = n_pl; b_first = n_first; b_last = n_last; b_ok = n_ok; b_err = n_err;
        b_ok_last = n_ok_last; b_fl_ok = n_fl_ok; b_plq = pl_log.size();
    endtask

    task automatic push16(input logic [15:0] w);
        fq.push_back(w[15:8]);
        fq.push_back(w[7:0]);
    endtask

    task automatic build(input logic [47:0] mac, input logic [15:0] etype, input logic [7:0] proto,
                         input logic [31:0] dip, input logic [15:0] port, input logic [15:0] ulen,
                         input logic [15:0] cs, input int npl);
        fq.delete();
        repeat (7) fq.push_back(8'h55);
        fq.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) fq.push_back(mac[i*8 +: 8]);
        push16(16'h0011); push16(16'h2233); push16(16'h4466);
        push16(etype);
        push16(16'h4500); push16(16'h0028); push16(16'h0000); push16(16'h4000);
        fq.push_back(8'h40); fq.push_back(proto);
        push16(cs);
        push16(16'hC0A8); push16(16'h0001);
        push16(dip[31:16]); push16(dip[15:0]);
        push16(16'd12345); push16(port); push16(ulen); push16(16'h0000);
        for (int i = 0; i < npl; i++) fq.push_back(hello[i]);
    endtask

    task automatic send(input int gap_at, input int gap_len, input int mark);
        snap();
        for (int i = 0; i < fq.size(); i++) begin
            if (i == gap_at) repeat (gap_len) tick(1'b0, 8'h00);
            tick(1'b1, fq[i]);
            if (i == mark) mark_cyc = cyc;
        end
        repeat (4) tick(1'b0, 8'h00);
    endtask

    task automatic good_frame(input string tag);
        build(MAC, 16'h0800, 8'h11, IP_OK, PORT, 16'd20, CS_OK, 12);
        send(-1, 0, -1);
        chk({tag, "_ok"}, 32'(n_ok - b_ok), 32'd1);
        chk({tag, "_noerr"}, 32'(n_err - b_err), 32'd0);
    endtask

    initial begin
        repeat (3) tick(1'b0, 8'h00);
        chk("rst_pl_valid", 32'(pl_valid), 32'd0);
        chk("rst_pkt_ok", 32'(pkt_ok), 32'd0);
        chk("rst_pkt_err", 32'(pkt_err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_src_ip", src_ip, 32'd0);
        chk("rst_pl_len", 32'(pl_len), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick(1'b0, 8'h00);

        // broadcast "Hello World!" frame
        build(BCAST, 16'h0800, 8'h11, IP_OK, PORT, 16'd20, CS_OK, 12);
        send(-1, 0, 61);
        chk("bc_npl", 32'(n_pl - b_pl), 32'd12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("bc_byte%0d", i), 32'(pl_log[b_plq + i]), 32'(hello[i]));
        chk("bc_nfirst", 32'(n_first - b_first), 32'd1);
        chk("bc_first", 32'(first_byte), 32'h48);
        chk("bc_last", 32'(last_byte), 32'h21);
        chk("bc_ok_last", 32'(n_ok_last - b_ok_last), 32'd1);
        chk("bc_ok", 32'(n_ok - b_ok), 32'd1);
        chk("bc_ok_time", 32'(ok_cyc), 32'(mark_cyc));
        chk("bc_src_port", 32'(src_port), 32'd12345);
        chk("bc_pl_len", 32'(pl_len), 32'd12);
        chk("bc_src_ip", src_ip, 32'hC0A80001);

        // wrong port, then an immediate good frame
        build(MAC, 16'h0800, 8'h11, IP_OK, 16'd1234, 16'd20, CS_OK, 12);
        send(-1, 0, 45);
        chk("port_err", 32'(n_err - b_err), 32'd1);
        chk("port_code", 32'(err_code), 32'd6);
        chk("port_err_time", 32'(err_cyc), 32'(mark_cyc));
        chk("port_npl", 32'(n_pl - b_pl), 32'd0);
        chk("port_nok", 32'(n_ok - b_ok), 32'd0);
        good_frame("after_port");
        chk("code_held", 32'(err_code), 32'd6);

        // short preamble
        fq.delete();
        fq.push_back(8'h55); fq.push_back(8'h55); fq.push_back(8'hD5);
        send(-1, 0, -1);
        chk("sfd_err", 32'(n_err - b_err), 32'd1);
        chk("sfd_code", 32'(err_code), 32'd9);

        // MAC, EtherType, protocol and dst IP rejects
        build(48'h000A_3501_0204, 16'h0800, 8'h11, IP_OK, PORT, 16'd20, CS_OK, 12);
        send(-1, 0, -1);
        chk("mac_code", 32'(err_code), 32'd1);
        build(MAC, 16'h86DD, 8'h11, IP_OK, PORT, 16'd20, CS_OK, 12);
        send(-1, 0, -1);
        chk("etype_code", 32'(err_code), 32'd2);
        build(MAC, 16'h0800, 8'h06, IP_OK, PORT, 16'd20, CS_OK, 12);
        send(-1, 0, -1);
        chk("proto_code", 32'(err_code), 32'd3);
        build(MAC, 16'h0800, 8'h11, 32'hC0A80063, PORT, 16'd20, CS_OK, 12);
        send(-1, 0, -1);
        chk("dip_code", 32'(err_code), 32'd4);
        chk("dip_nok", 32'(n_ok - b_ok), 32'd0);

        // UDP length boundaries
        build(MAC, 16'h0800, 8'h11, IP_OK, PORT, 16'd7, CS_OK, 0);
        send(-1, 0, -1);
        chk("len7_err", 32'(n_err - b_err), 32'd1);
        chk("len7_code", 32'(err_code), 32'd7);
        build(MAC, 16'h0800, 8'h11, IP_OK, PORT, 16'd8, CS_OK, 0);
        send(-1, 0, 49);
        chk("len8_ok", 32'(n_ok - b_ok), 32'd1);
        chk("len8_time", 32'(ok_cyc), 32'(mark_cyc));
        chk("len8_npl", 32'(n_pl - b_pl), 32'd0);
        chk("len8_pl_len", 32'(pl_len), 32'd0);
        build(MAC, 16'h0800, 8'h11, IP_OK, PORT, 16'd9, CS_OK, 1);
        send(-1, 0, -1);
        chk("len9_fl_ok", 32'(n_fl_ok - b_fl_ok), 32'd1);
        chk("len9_npl", 32'(n_pl - b_pl), 32'd1);

        // mid-frame gap after IP byte 5
        build(MAC, 16'h0800, 8'h11, IP_OK, PORT, 16'd20, CS_OK, 12);
        send(28, 1000, -1);
        chk("gap1000_err", 32'(n_err - b_err), 32'd1);
        chk("gap1000_code", 32'(err_code), 32'd8);
        chk("gap1000_nok", 32'(n_ok - b_ok), 32'd0);
        send(28, 999, -1);
        chk("gap999_ok", 32'(n_ok - b_ok), 32'd1);
        chk("gap999_noerr", 32'(n_err - b_err), 32'd0);

        // zeroed IP checksum
        build(MAC, 16'h0800, 8'h11, IP_OK, PORT, 16'd20, 16'h0000, 12);
        send(-1, 0, -1);
`ifdef UDP_RX_IP_CSUM_EN
        chk("csum0_err", 32'(n_err - b_err), 32'd1);
        chk("csum0_code", 32'(err_code), 32'd5);
`else
        chk("csum0_ok", 32'(n_ok - b_ok), 32'd1);
        chk("csum0_noerr", 32'(n_err - b_err), 32'd0);
`endif

        // reset during payload byte 6
        build(BCAST, 16'h0800, 8'h11, IP_OK, PORT, 16'd20, CS_OK, 12);
        snap();
        for (int i = 0; i < 56; i++) tick(1'b1, fq[i]);
        rx_valid = 1'b1;
        rx_data  = fq[56];
        reset_n  = 1'b0;
        #1;
        chk("mrst_pl_valid", 32'(pl_valid), 32'd0);
        chk("mrst_pl_data", 32'(pl_data), 32'd0);
        chk("mrst_err_code", 32'(err_code), 32'd0);
        chk("mrst_src_ip", src_ip, 32'd0);
        chk("mrst_src_port", 32'(src_port), 32'd0);
        chk("mrst_pl_len", 32'(pl_len), 32'd0);
        repeat (3) tick(1'b0, 8'h00);
        reset_n = 1'b1;
        repeat (3) tick(1'b0, 8'h00);
        chk("mrst_noerr", 32'(n_err - b_err), 32'd0);
        good_frame("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
